// File: rtl/path_replay_ctrl.sv
// path_replay_ctrl
// Sequencer that sits between the solver FSM and the path output unit. It drains
// the 2-bit direction stack into a local buffer. It then replays the buffered path
// on a valid/ready stream, first move first, and re-inits the stack afterwards.
//
// Ports
//   CLK         in   system clock, rising edge
//   RST         in   asynchronous reset, active-high
//   start       in   one-cycle request to drain and replay; ignored while busy
//   stk_empty   in   stack empty flag (combinational from the stack index)
//   stk_dout    in   stack data, valid the cycle after the stk_pop cycle
//   stk_pop     out  pop strobe to the stack
//   stk_init    out  init strobe to the stack
//   move_valid  out  replay data valid
//   move_ready  in   consumer accepts move_dir while move_valid is high
//   move_dir    out  current direction
//   move_last   out  high together with the final move of the path
//   path_len    out  number of moves captured; held until the next start
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse at the end of a sequence
//   overflow    out  sticky; the buffer filled before the stack emptied
module path_replay_ctrl #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 256
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       start,
    input  logic                       stk_empty,
    input  logic [WIDTH-1:0]           stk_dout,
    output logic                       stk_pop,
    output logic                       stk_init,
    output logic                       move_valid,
    input  logic                       move_ready,
    output logic [WIDTH-1:0]           move_dir,
    output logic                       move_last,
    output logic [$clog2(DEPTH):0]     path_len,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_CAPT,
        S_EMIT,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [AW-1:0]   rd_reg, rd_next;
    logic            overflow_reg, overflow_next;
    logic            buf_we;

    // Local path buffer. Its contents are don't-care after reset, so it has no reset.
    logic [WIDTH-1:0] buf_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (buf_we) begin
            buf_mem[cnt_reg[AW-1:0]] <= stk_dout;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            rd_reg       <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            rd_reg       <= rd_next;
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        rd_next       = rd_reg;
        overflow_next = overflow_reg;
        buf_we        = 1'b0;
        stk_pop       = 1'b0;
        stk_init      = 1'b0;
        move_valid    = 1'b0;
        move_dir      = '0;
        move_last     = 1'b0;
        done          = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    cnt_next      = '0;
                    overflow_next = 1'b0;
                    // An empty stack has nothing to replay and needs no init.
                    state_next    = stk_empty ? S_DONE : S_POP;
                end
            end
            S_POP: begin
                stk_pop    = 1'b1;
                state_next = S_CAPT;
            end
            S_CAPT: begin
                // stk_dout now holds the popped entry. stk_empty already reflects
                // the decremented index, so it tells us whether this was the last entry.
                buf_we   = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (stk_empty) begin
                    rd_next    = cnt_reg[AW-1:0];
                    state_next = S_EMIT;
                end else if (cnt_reg + 1'b1 == DEPTH_C) begin
                    overflow_next = 1'b1;
                    state_next    = S_CLEAR;
                end else begin
                    state_next = S_POP;
                end
            end
            S_EMIT: begin
                // The buffer holds entries newest-first, so reading downward from
                // the last captured index restores the original push order.
                move_valid = 1'b1;
                move_dir   = buf_mem[rd_reg];
                move_last  = (rd_reg == '0);
                if (move_ready) begin
                    if (rd_reg == '0) begin
                        state_next = S_CLEAR;
                    end else begin
                        rd_next = rd_reg - 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                stk_init   = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_reg != S_IDLE);
    assign path_len = cnt_reg;
    assign overflow = overflow_reg;

endmodule
